fifo_drain: RTL and testbench

Burst read-side controller for the codebase's dual-clock `fifo`, running entirely in the FIFO's read-clock domain. On a `start` request it pops a programmed number of words through the FIFO's `read_enable`/`fifo_empty`/`q` port. It absorbs the FIFO's one-cycle read latency and presents the words on a valid/ready stream toward downstream logic. An internal 4-entry skid buffer sustains one word per cycle under full-rate downstream acceptance.

---
 rtl/fifo_drain_pkg.sv | 15 +
 rtl/fifo_drain_buf.sv | 52 +++++
 rtl/fifo_drain.sv | 114 +++++++++++
 tb/tb_fifo_drain.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the fifo_drain burst read controller:
// FSM state encoding and skid-buffer geometry.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BUF_DEPTH    = 4;
    localparam int BUF_PTR_BITS = 2;

endpackage

// File: rtl/fifo_drain_buf.sv
// Four-entry circular skid buffer with push/pop strobes and an occupancy count.
// Storage is not reset; only the pointers and count are.
module fifo_drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_push_data,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_head,
    output logic [BUF_PTR_BITS:0]   o_count
);

    logic [DATA_WIDTH-1:0]   r_mem [BUF_DEPTH];
    logic [BUF_PTR_BITS-1:0] r_wr_ptr;
    logic [BUF_PTR_BITS-1:0] r_rd_ptr;
    logic [BUF_PTR_BITS:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally at 2 bits; count tracks full vs. empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + BUF_PTR_BITS'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + BUF_PTR_BITS'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (BUF_PTR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (BUF_PTR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fifo_drain.sv
// Burst read-side controller: pops a programmed number of words from the FIFO,
// absorbs its one-cycle read latency and streams them out through a skid buffer.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 8
) (
    input  logic                  read_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_BITS-1:0]   burst_len,
    output logic                  read_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_BITS-1:0]   words_left
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [LEN_BITS-1:0]     r_words_left;
    logic [LEN_BITS-1:0]     w_words_left_nxt;
    logic                    r_inflight;
    logic [BUF_PTR_BITS:0]   w_occ;
    logic [BUF_PTR_BITS+1:0] w_slots_used;
    logic [DATA_WIDTH-1:0]   w_head;
    logic                    w_rd_en;
    logic                    w_pop;
    logic                    w_valid;
    logic                    w_xfer;

    // A pop reserves a slot a cycle before its data lands, so the in-flight
    // word counts against capacity; out_ready is deliberately kept out of this.
    assign w_slots_used = {1'b0, w_occ} + {{(BUF_PTR_BITS+1){1'b0}}, r_inflight};
    assign w_rd_en      = (r_state == ST_DRAIN) && (r_words_left != '0)
                          && (w_slots_used < (BUF_PTR_BITS+2)'(BUF_DEPTH));
    assign w_pop        = w_rd_en && !fifo_empty;
    assign w_valid      = (w_occ != '0);
    assign w_xfer       = w_valid && out_ready;

    fifo_drain_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk       (read_clock),
        .i_rst_n     (reset),
        .i_push      (r_inflight),
        .i_push_data (q),
        .i_pop       (w_xfer),
        .o_head      (w_head),
        .o_count     (w_occ)
    );

    always_ff @(posedge read_clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_words_left <= w_words_left_nxt;
            r_inflight   <= w_pop;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_words_left_nxt = r_words_left;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_words_left_nxt = burst_len;
                    w_state_nxt      = (burst_len == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop) begin
                    w_words_left_nxt = r_words_left - LEN_BITS'(1);
                end
                // An abort still lets a same-edge pop land via r_inflight.
                if (abort) begin
                    w_state_nxt      = ST_FLUSH;
                    w_words_left_nxt = '0;
                end else if (w_pop && (r_words_left == LEN_BITS'(1))) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!r_inflight && (w_occ == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign read_enable = w_rd_en;
    assign out_valid   = w_valid;
    assign out_data    = w_valid ? w_head : '0;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign words_left  = r_words_left;

endmodule

// File: tb/tb_fifo_drain.sv
// Randomized bench for fifo_drain: an emulated FIFO plus a queue-based
// behavioural model compared against the DUT outputs every cycle.
module tb_fifo_drain;

    localparam int DW = 32;
    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [LB-1:0] burst_len;
    logic          read_enable;
    logic          fifo_empty;
    logic [DW-1:0] q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [LB-1:0] words_left;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(DW), .LEN_BITS(LB)) dut (
        .read_clock  (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .burst_len   (burst_len),
        .read_enable (read_enable),
        .fifo_empty  (fifo_empty),
        .q           (q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .words_left  (words_left)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q[$];

    // Model: phase 0 idle, 1 draining, 2 flushing, 3 done.
    int            m_phase = 0;
    int            m_left = 0;
    bit            m_infl = 0;
    bit            m_known = 0;
    logic [DW-1:0] m_buf[$];

    int            cyc = 0;
    int            pops = 0;
    int            re_cnt = 0;
    int            done_cnt = 0;
    int            done_idx = -1;
    int            first_valid = -1;
    logic [DW-1:0] got[$];
    int            got_idx[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic begin_test();
        got.delete();
        got_idx.delete();
        pops        = 0;
        re_cnt      = 0;
        done_cnt    = 0;
        done_idx    = -1;
        first_valid = -1;
    endtask

    task automatic cycle();
        bit            re_m, v_m, pop_m, xfer_m, pop_d, old_infl;
        int            old_sz;
        logic [DW-1:0] d_m, q_edge;
        @(negedge clk);
        re_m = (m_phase == 1) && (m_left > 0) && ((m_buf.size() + int'(m_infl)) < 4);
        v_m  = (m_buf.size() > 0);
        d_m  = v_m ? m_buf[0] : '0;
        if (m_known) begin
            chk("read_enable", read_enable, re_m);
            chk("out_valid", out_valid, v_m);
            chk("out_data", out_data, d_m);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 3);
            chk("words_left", words_left, 64'(m_left));
        end
        pop_d = read_enable && !fifo_empty;
        if (read_enable) re_cnt++;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_idx.push_back(cyc);
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
            done_cnt++;
            done_idx = cyc;
        end
        pop_m  = re_m && !fifo_empty;
        xfer_m = v_m && out_ready;
        @(posedge clk);
        #1;
        q_edge = q;
        if (pop_d) begin
            pops++;
            q = fifo_q.pop_front();
        end
        if (!reset) begin
            m_phase = 0;
            m_left  = 0;
            m_infl  = 0;
            m_buf.delete();
            m_known = 1;
        end else begin
            old_infl = m_infl;
            old_sz   = m_buf.size();
            if (xfer_m) void'(m_buf.pop_front());
            if (old_infl) m_buf.push_back(q_edge);
            m_infl = pop_m;
            case (m_phase)
                0: if (start) begin
                       m_left  = int'(burst_len);
                       m_phase = (burst_len == 0) ? 3 : 1;
                   end
                1: begin
                       if (pop_m) m_left--;
                       if (abort) begin
                           m_phase = 2;
                           m_left  = 0;
                       end else if (pop_m && m_left == 0) begin
                           m_phase = 2;
                       end
                   end
                2: if (!old_infl && old_sz == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            cycle();
            k++;
        end
        if (done_cnt == d0) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic start_burst(input int n);
        burst_len = LB'(n);
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    initial begin
        int            s;
        int            k;
        int            n;
        logic [DW-1:0] exp_w[$];

        reset = 1'b0; start = 1'b0; abort = 1'b0; burst_len = '0;
        out_ready = 1'b0; q = '0; fifo_empty = 1'b1;
        run(2);
        reset = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_words_left", words_left, 0);
        chk("rst_read_enable", read_enable, 0);
        run(2);

        // Basic drain of 0x11..0x15.
        begin_test();
        for (int i = 0; i < 5; i++) fifo_write(DW'(32'h11 + i));
        out_ready = 1'b1;
        s = cyc;
        start_burst(5);
        wait_done("basic", 50);
        run(3);
        chk("basic_latency", 64'(first_valid - s), 3);
        chk("basic_pops", pops, 5);
        chk("basic_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("basic_data", got[i], 64'(32'h11 + i));
        if (got.size() == 5) chk("basic_consecutive", 64'(got_idx[4] - got_idx[0]), 4);
        chk("basic_done_pulses", done_cnt, 1);

        // Backpressure: only the buffer's worth of pops while stalled.
        begin_test();
        exp_w.delete();
        for (int i = 0; i < 8; i++) begin
            exp_w.push_back($urandom);
            fifo_write(exp_w[i]);
        end
        out_ready = 1'b0;
        start_burst(8);
        run(10);
        chk("bp_pops", pops, 4);
        chk("bp_read_enable_low", read_enable, 0);
        chk("bp_nothing_out", got.size(), 0);
        out_ready = 1'b1;
        wait_done("bp", 60);
        chk("bp_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_data", got[i], exp_w[i]);

        // Empty FIFO stall, then supply.
        begin_test();
        start_burst(3);
        run(10);
        chk("stall_pops", pops, 0);
        chk("stall_busy", busy, 1);
        exp_w.delete();
        for (int i = 0; i < 3; i++) begin
            exp_w.push_back($urandom);
            fifo_write(exp_w[i]);
        end
        wait_done("stall", 40);
        chk("stall_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("stall_data", got[i], exp_w[i]);

        // Zero length.
        begin_test();
        s = cyc;
        start_burst(0);
        wait_done("zero", 10);
        run(2);
        chk("zero_no_read_enable", re_cnt, 0);
        chk("zero_done_latency", (done_idx - s) >= 1 && (done_idx - s) <= 2, 1);
        chk("zero_done_pulses", done_cnt, 1);

        // Abort after the third pop.
        begin_test();
        exp_w.delete();
        for (int i = 0; i < 10; i++) begin
            exp_w.push_back($urandom);
            fifo_write(exp_w[i]);
        end
        start_burst(10);
        k = 0;
        while (pops < 3 && k < 20) begin
            cycle();
            k++;
        end
        chk("abort_reached_3_pops", pops, 3);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_words_left", words_left, 0);
        wait_done("abort", 40);
        chk("abort_at_most_4", got.size() <= 4, 1);
        chk("abort_at_least_3", got.size() >= 3, 1);
        for (int i = 0; i < got.size(); i++) chk("abort_data", got[i], exp_w[i]);
        fifo_q.delete();
        fifo_empty = 1'b1;

        // Reset while two words are buffered.
        begin_test();
        for (int i = 0; i < 8; i++) fifo_write($urandom);
        out_ready = 1'b0;
        start_burst(8);
        k = 0;
        while (m_buf.size() != 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("rstmid_occ2", m_buf.size(), 2);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_words_left", words_left, 0);
        begin_test();
        exp_w.delete();
        exp_w.push_back(fifo_q[0]);
        exp_w.push_back(fifo_q[1]);
        out_ready = 1'b1;
        start_burst(2);
        wait_done("rstmid", 30);
        chk("rstmid_count", got.size(), 2);
        for (int i = 0; i < 2 && i < got.size(); i++) chk("rstmid_data", got[i], exp_w[i]);
        fifo_q.delete();
        fifo_empty = 1'b1;

        // Randomized bursts with random supply, backpressure and aborts.
        for (int b = 0; b < 25; b++) begin
            begin_test();
            n = $urandom_range(0, 12);
            for (int i = 0; i < int'($urandom_range(0, n)); i++) fifo_write($urandom);
            start_burst(n);
            k = 0;
            while (done_cnt == 0 && k < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) fifo_write($urandom);
                abort = ($urandom_range(0, 40) == 0);
                cycle();
                k++;
            end
            abort = 1'b0;
            if (done_cnt == 0) chk("rnd_done_timeout", 0, 1);
            chk("rnd_no_loss", got.size(), pops);
            run(2);
            fifo_q.delete();
            fifo_empty = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
